truth_table_checker: RTL and testbench

- Hardware self-checker for the 5-input function block F(A,B,C,D,G).
- On start, it drives all 32 input combinations to the function block in order, holds each one for a settle window, then samples F. It compares F against a parameterised expected truth table.
- It reports the pass/fail verdict, the mismatch count and the first failing vector, plus a per-vector log strobe.
- It replaces the open-loop simulation sweep with synthesizable on-chip exhaustive checking.

---
 rtl/truth_table_pkg.sv | 17 +
 rtl/truth_table_checker_sweep.sv | 51 +++++
 rtl/truth_table_checker.sv | 135 +++++++++++++
 tb/tb_truth_table_checker.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/truth_table_pkg.sv
// Shared constants and state type for the on-chip truth-table checker.
package truth_table_pkg;

  localparam int unsigned NUM_VECTORS = 32;
  localparam int unsigned VEC_W       = 5;
  localparam int unsigned CNT_W       = 6;

  // Expected F(A,B,C,D,G); zero at vectors 2, 4, 7, 13, 19, 24 and 26.
  localparam logic [NUM_VECTORS-1:0] FUNC_F_EXPECT = 32'hFAF7_DF6B;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/truth_table_checker_sweep.sv
// Vector index plus settle down-counter; flags the sample edge of each vector.
module vector_sweep_counter
  import truth_table_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enable,
  output logic [VEC_W-1:0] stim,
  output logic             sample,
  output logic             last
);

  localparam logic [7:0] RELOAD = 8'(SETTLE_CYCLES - 1);

  logic [VEC_W-1:0] idx_q, idx_d;
  logic [7:0]       cnt_q, cnt_d;

  assign stim   = idx_q;
  assign last   = (idx_q == '1);
  assign sample = enable && (cnt_q == '0);

  always_comb begin
    idx_d = idx_q;
    cnt_d = cnt_q;
    if (load) begin
      idx_d = '0;
      cnt_d = RELOAD;
    end else if (enable) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 8'd1;
      end else if (!last) begin
        idx_d = idx_q + VEC_W'(1);
        cnt_d = RELOAD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
      cnt_q <= '0;
    end else begin
      idx_q <= idx_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/truth_table_checker.sv
// Exhaustive 32-vector sweep of F(A,B,C,D,G) against an expected truth table.
module truth_table_checker
  import truth_table_pkg::*;
#(
  parameter int unsigned            SETTLE_CYCLES = 4,
  parameter logic [NUM_VECTORS-1:0] EXPECT_MASK   = FUNC_F_EXPECT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [VEC_W-1:0] stim,
  input  logic             f_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic             first_fail_valid,
  output logic [VEC_W-1:0] first_fail_idx,
  output logic             log_valid,
  output logic [VEC_W-1:0] log_idx,
  output logic             log_f,
  output logic             log_exp
);

  state_e           state_q, state_d;
  logic             pass_q, pass_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             ffv_q, ffv_d;
  logic [VEC_W-1:0] ffi_q, ffi_d;
  logic             lv_q, lv_d;
  logic [VEC_W-1:0] lidx_q, lidx_d;
  logic             lf_q, lf_d;
  logic             lexp_q, lexp_d;

  logic             load, enable, sample, last;
  logic             exp_bit, mismatch;
  logic [CNT_W-1:0] err_inc;

  assign load   = (state_q != RUN) && start;
  assign enable = (state_q == RUN);

  vector_sweep_counter #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_sweep (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .enable(enable),
    .stim  (stim),
    .sample(sample),
    .last  (last)
  );

  assign exp_bit  = EXPECT_MASK[stim];
  assign mismatch = f_in ^ exp_bit;
  assign err_inc  = err_q + {{(CNT_W-1){1'b0}}, mismatch};

  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    ffi_d   = ffi_q;
    lv_d    = 1'b0;
    lidx_d  = lidx_q;
    lf_d    = lf_q;
    lexp_d  = lexp_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          pass_d  = 1'b0;
          err_d   = '0;
          ffv_d   = 1'b0;
          ffi_d   = '0;
        end
      end
      RUN: begin
        if (sample) begin
          err_d  = err_inc;
          lv_d   = 1'b1;
          lidx_d = stim;
          lf_d   = f_in;
          lexp_d = exp_bit;
          if (mismatch && !ffv_q) begin
            ffv_d = 1'b1;
            ffi_d = stim;
          end
          // Verdict must include the vector-31 result sampled on this same edge.
          if (last) begin
            state_d = DONE;
            pass_d  = (err_inc == '0);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ffv_q   <= 1'b0;
      ffi_q   <= '0;
      lv_q    <= 1'b0;
      lidx_q  <= '0;
      lf_q    <= 1'b0;
      lexp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffi_q   <= ffi_d;
      lv_q    <= lv_d;
      lidx_q  <= lidx_d;
      lf_q    <= lf_d;
      lexp_q  <= lexp_d;
    end
  end

  assign busy             = (state_q == RUN);
  assign done             = (state_q == DONE);
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_idx   = ffi_q;
  assign log_valid        = lv_q;
  assign log_idx          = lidx_q;
  assign log_f            = lf_q;
  assign log_exp          = lexp_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed and randomized sweeps of truth_table_checker against a table-driven reference.
module tb_truth_table_checker;

  localparam int S4 = 4;

  logic        clk = 1'b0;
  logic        rst, start, start1;
  logic [31:0] exp_tab;
  logic [31:0] fvec;

  logic [4:0] stim, first_fail_idx, log_idx;
  logic [5:0] err_count;
  logic       f_in, busy, done, pass, first_fail_valid, log_valid, log_f, log_exp;

  logic [4:0] stim1, ffi1, lidx1;
  logic [5:0] err1;
  logic       f_in1, busy1, done1, pass1, ffv1, lv1, lf1, lexp1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign f_in  = fvec[stim];
  assign f_in1 = exp_tab[stim1];

  truth_table_checker #(.SETTLE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stim(stim), .f_in(f_in),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_fail_valid(first_fail_valid), .first_fail_idx(first_fail_idx),
    .log_valid(log_valid), .log_idx(log_idx), .log_f(log_f), .log_exp(log_exp)
  );

  truth_table_checker #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .stim(stim1), .f_in(f_in1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_fail_valid(ffv1), .first_fail_idx(ffi1),
    .log_valid(lv1), .log_idx(lidx1), .log_f(lf1), .log_exp(lexp1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One full sweep on the S=4 instance with function vector fv; all timing checked per edge.
  task automatic run_sweep(input logic [31:0] fv, input bit hold);
    int e;
    int ff;
    int k;
    bit lv;
    e  = 0;
    ff = -1;
    for (int i = 0; i < 32; i++) begin
      if (fv[i] !== exp_tab[i]) begin
        e++;
        if (ff < 0) ff = i;
      end
    end
    fvec  = fv;
    start = 1'b1;
    tick();
    check("edge0_busy", 32'(busy), 32'd1);
    check("edge0_done", 32'(done), 32'd0);
    check("edge0_err", 32'(err_count), 32'd0);
    check("edge0_ffv", 32'(first_fail_valid), 32'd0);
    check("edge0_stim", 32'(stim), 32'd0);
    if (!hold) start = 1'b0;
    for (int cyc = 1; cyc <= 32*S4 + 3; cyc++) begin
      if (hold && cyc == 32*S4) start = 1'b0;
      tick();
      check("busy", 32'(busy), 32'(cyc < 32*S4));
      check("done", 32'(done), 32'(cyc >= 32*S4));
      lv = (cyc % S4 == 0) && (cyc <= 32*S4);
      check("log_valid", 32'(log_valid), 32'(lv));
      if (lv) begin
        k = cyc / S4 - 1;
        check("log_idx", 32'(log_idx), 32'(k));
        check("log_f", 32'(log_f), 32'(fv[k]));
        check("log_exp", 32'(log_exp), 32'(exp_tab[k]));
      end
      if (cyc < 32*S4) check("stim", 32'(stim), 32'(cyc / S4));
    end
    check("final_err", 32'(err_count), 32'(e));
    check("final_pass", 32'(pass), 32'(e == 0));
    check("final_ffv", 32'(first_fail_valid), 32'(e > 0));
    if (e > 0) check("final_ffi", 32'(first_fail_idx), 32'(ff));
    check("final_stim", 32'(stim), 32'd31);
  endtask

  initial begin
    bit found;
    logic [31:0] flip;
    int zeros [7] = '{2, 4, 7, 13, 19, 24, 26};
    exp_tab = '1;
    foreach (zeros[z]) exp_tab[zeros[z]] = 1'b0;
    fvec   = exp_tab;
    rst    = 1'b1;
    start  = 1'b0;
    start1 = 1'b0;
    tick();
    tick();
    check("rst_stim", 32'(stim), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    check("rst_logv", 32'(log_valid), 32'd0);
    rst = 1'b0;
    tick();

    // Working function block, then F stuck at 1 and stuck at 0.
    run_sweep(exp_tab, 1'b0);
    run_sweep(32'hFFFF_FFFF, 1'b0);
    run_sweep(32'h0000_0000, 1'b0);
    // Single fault on the last vector must still fail the sweep.
    run_sweep(exp_tab ^ 32'h8000_0000, 1'b0);
    repeat (4) begin
      flip = $urandom() & $urandom();
      run_sweep(exp_tab ^ flip, 1'b0);
    end

    // Mid-sweep reset with a fault already logged at vector 3.
    fvec  = exp_tab ^ 32'h0000_0008;
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      tick();
      if (stim == 5'd10) found = 1'b1;
    end
    check("reach_stim10", 32'(found), 32'd1);
    check("pre_rst_ffv", 32'(first_fail_valid), 32'd1);
    rst = 1'b1;
    tick();
    check("mrst_stim", 32'(stim), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_pass", 32'(pass), 32'd0);
    check("mrst_err", 32'(err_count), 32'd0);
    check("mrst_ffv", 32'(first_fail_valid), 32'd0);
    check("mrst_ffi", 32'(first_fail_idx), 32'd0);
    check("mrst_logv", 32'(log_valid), 32'd0);
    check("mrst_logi", 32'(log_idx), 32'd0);
    check("mrst_logf", 32'(log_f), 32'd0);
    check("mrst_loge", 32'(log_exp), 32'd0);
    rst = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 32'd0);
    run_sweep(exp_tab, 1'b0);

    // start held through a faulty sweep, then a restart from DONE clears and repeats.
    run_sweep(exp_tab ^ 32'h0001_0040, 1'b1);
    repeat (3) tick();
    check("held_no_restart", 32'(done), 32'd1);
    run_sweep(exp_tab ^ 32'h0001_0040, 1'b0);

    // S=1 instance: stim advances every edge, done at edge 32.
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("s1_edge0_stim", 32'(stim1), 32'd0);
    check("s1_edge0_busy", 32'(busy1), 32'd1);
    for (int cyc = 1; cyc <= 34; cyc++) begin
      tick();
      if (cyc < 32) check("s1_stim", 32'(stim1), 32'(cyc));
      check("s1_done", 32'(done1), 32'(cyc >= 32));
      check("s1_logv", 32'(lv1), 32'(cyc <= 32));
      if (cyc <= 32) check("s1_logi", 32'(lidx1), 32'(cyc - 1));
    end
    check("s1_pass", 32'(pass1), 32'd1);
    check("s1_err", 32'(err1), 32'd0);
    check("s1_ffv", 32'(ffv1), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
